// File: rtl/add_round_key_seq.sv
// AES-128 encrypt AddRoundKey stage with on-the-fly key expansion.
// Holds one round key at a time and advances it once per accepted state word.
module add_round_key_seq #(
    parameter int NR = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic         in_valid_i,
    input  logic [127:0] in_i,
    output logic [127:0] out_o,
    output logic         out_valid_o,
    output logic [3:0]   round_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [1:0]   state_dbg_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [3:0] NR_L = 4'(NR);

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [10:0] idx;
        idx  = 11'd2047 - {a, 3'b000};
        sbox = SBOX[idx -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    state_t         state_q, state_d;
    logic [127:0]   key_q, key_d;
    logic [127:0]   out_q, out_d;
    logic           out_valid_q, out_valid_d;
    logic [3:0]     round_q, round_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [3:0]     round_next;
    logic [31:0]    w0, w1, w2, w3, w4, w5, w6, w7;
    logic [31:0]    rot_w, t_w;
    logic [127:0]   next_key;

    // Key schedule step for round round_q + 1.
    always_comb begin
        round_next = round_q + 4'd1;
        {w0, w1, w2, w3} = key_q;
        rot_w = {w3[23:0], w3[31:24]};
        t_w   = {sbox(rot_w[31:24]), sbox(rot_w[23:16]),
                 sbox(rot_w[15:8]),  sbox(rot_w[7:0])}
                ^ {rcon(round_next), 24'h0};
        w4 = w0 ^ t_w;
        w5 = w1 ^ w4;
        w6 = w2 ^ w5;
        w7 = w3 ^ w6;
        next_key = {w4, w5, w6, w7};
    end

    // Start has priority over a coincident in_valid, from any state.
    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        round_d     = round_q;
        busy_d      = busy_q;
        done_d      = done_q;
        if (start_i) begin
            state_d = RUN;
            key_d   = key_i;
            round_d = 4'd0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
        end else if (state_q == RUN && in_valid_i) begin
            key_d       = next_key;
            out_d       = in_i ^ next_key;
            round_d     = round_next;
            out_valid_d = 1'b1;
            if (round_next == NR_L) begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            key_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            round_q     <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            round_q     <= round_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_o       = out_q;
    assign out_valid_o = out_valid_q;
    assign round_o     = round_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_add_round_key_seq.sv
// Bench for add_round_key_seq: GF(2^8)-derived key-schedule model checked every
// cycle, plus FIPS-197 round-key literals at the key points.
module tb_add_round_key_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key = '0;
    logic         in_valid = 1'b0;
    logic [127:0] din = '0;
    logic [127:0] out;
    logic         out_valid;
    logic [3:0]   round;
    logic         busy;
    logic         done;
    logic [1:0]   state_dbg;

    always #5 clk = ~clk;

    add_round_key_seq #(.NR(10)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .key_i       (key),
        .in_valid_i  (in_valid),
        .in_i        (din),
        .out_o       (out),
        .out_valid_o (out_valid),
        .round_o     (round),
        .busy_o      (busy),
        .done_o      (done),
        .state_dbg_o (state_dbg)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: S-box derived from the field inverse plus affine map
    logic [7:0] sbox_m [256];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] expand(input logic [127:0] k, input int r);
        logic [7:0]  rc;
        logic [31:0] w [8];
        logic [31:0] rw, t;
        rc = 8'h01;
        for (int i = 1; i < r; i++) rc = gmul(rc, 8'h02);
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rw = {w[3][23:0], w[3][31:24]};
        t = {sbox_m[rw[31:24]], sbox_m[rw[23:16]], sbox_m[rw[15:8]], sbox_m[rw[7:0]]}
            ^ {rc, 24'h0};
        w[4] = w[0] ^ t;
        for (int i = 5; i < 8; i++) w[i] = w[i-4] ^ w[i-1];
        return {w[4], w[5], w[6], w[7]};
    endfunction

    logic [127:0] m_key, m_out;
    logic         m_ov, m_busy, m_done, m_run;
    int           m_round;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_key = '0; m_out = '0; m_ov = 0; m_round = 0;
            m_busy = 0; m_done = 0; m_run = 0;
        end else begin
            m_ov = 0;
            if (start) begin
                m_key = key; m_round = 0; m_busy = 1; m_done = 0; m_run = 1;
            end else if (in_valid && m_run) begin
                m_round = m_round + 1;
                m_key = expand(m_key, m_round);
                m_out = din ^ m_key;
                m_ov = 1;
                if (m_round == 10) begin
                    m_run = 0; m_busy = 0; m_done = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_out", out, m_out);
        chk("cyc_out_valid", 128'(out_valid), 128'(m_ov));
        chk("cyc_round", 128'(round), 128'(m_round));
        chk("cyc_busy", 128'(busy), 128'(m_busy));
        chk("cyc_done", 128'(done), 128'(m_done));
    end

    task automatic drive(input logic s, input logic [127:0] k, input logic v, input logic [127:0] d);
        @(negedge clk);
        start = s; key = k; in_valid = v; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        start = 0; key = '0; in_valid = 0; din = '0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

    initial begin
        build_sbox();
        chk("model_sbox_00", 128'(sbox_m[8'h00]), 128'h63);
        chk("model_sbox_53", 128'(sbox_m[8'h53]), 128'hed);
        chk("model_expand_a1", expand(KEY_A, 1), 128'ha0fafe1788542cb123a339392a6c7605);

        repeat (2) @(negedge clk);
        rst = 0;

        // in_valid in IDLE after reset is ignored
        drive(0, '0, 1, rnd128());
        chk("idle_ov", 128'(out_valid), 128'h0);
        chk("idle_round", 128'(round), 128'h0);
        chk("idle_out", out, 128'h0);
        idle();

        // FIPS-197 key with zero state: output is the round key itself
        drive(1, KEY_A, 0, '0);
        chk("start_busy", 128'(busy), 128'h1);
        drive(0, '0, 1, '0);
        chk("a_r1_out", out, 128'ha0fafe1788542cb123a339392a6c7605);
        chk("a_r1_round", 128'(round), 128'h1);
        chk("a_r1_ov", 128'(out_valid), 128'h1);
        drive(0, '0, 1, '0);
        chk("a_r2_out", out, 128'hf2c295f27a96b9435935807a7359f67f);
        chk("a_r2_round", 128'(round), 128'h2);
        chk("a_r2_ov", 128'(out_valid), 128'h1);
        drive(0, '0, 1, '0);
        chk("a_r3_out", out, 128'h3d80477d4716fe3e1e237e446d7a883b);

        // Start together with in_valid at round 3: restart wins
        drive(1, KEY_B, 1, rnd128());
        chk("restart_round", 128'(round), 128'h0);
        chk("restart_ov", 128'(out_valid), 128'h0);
        chk("restart_out_held", out, 128'h3d80477d4716fe3e1e237e446d7a883b);
        drive(0, '0, 1, '0);
        chk("restart_r1_out", out, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        chk("restart_r1_round", 128'(round), 128'h1);

        // Non-zero state word
        drive(1, KEY_B, 0, '0);
        drive(0, '0, 1, 128'h5f72641557f5bc92f7be3b291db9f91a);
        chk("b_data_out", out, 128'h89d810e8855ace682d1843d8cb128fe4);
        chk("b_data_round", 128'(round), 128'h1);

        // Ten back-to-back beats to completion, then one extra
        drive(1, KEY_B, 0, '0);
        for (int i = 1; i <= 10; i++) begin
            drive(0, '0, 1, '0);
            if (i == 2) chk("b_r2_out", out, 128'hb692cf0b643dbdf1be9bc5006830b3fe);
        end
        chk("b_r10_out", out, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        chk("b_r10_round", 128'(round), 128'ha);
        chk("b_r10_done", 128'(done), 128'h1);
        chk("b_r10_busy", 128'(busy), 128'h0);
        drive(0, '0, 1, rnd128());
        chk("b_r11_ov", 128'(out_valid), 128'h0);
        chk("b_r11_out_held", out, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        chk("b_r11_round", 128'(round), 128'ha);
        idle();

        // Async reset in the middle of round 4
        drive(1, KEY_A, 0, '0);
        for (int i = 0; i < 4; i++) drive(0, '0, 1, rnd128());
        chk("pre_rst_round", 128'(round), 128'h4);
        #2 rst = 1;
        #1;
        chk("rst_out", out, 128'h0);
        chk("rst_ov", 128'(out_valid), 128'h0);
        chk("rst_round", 128'(round), 128'h0);
        chk("rst_busy", 128'(busy), 128'h0);
        chk("rst_done", 128'(done), 128'h0);
        @(negedge clk);
        rst = 0;
        drive(0, '0, 1, rnd128());
        chk("post_rst_ov", 128'(out_valid), 128'h0);
        chk("post_rst_round", 128'(round), 128'h0);
        idle();

        // A few random data beats with the model tracking them
        drive(1, rnd128(), 0, '0);
        for (int i = 0; i < 6; i++) drive(0, '0, 1, rnd128());
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
